// File: rtl/seq_core_ctrl_if.sv
// Handshake bundle between the sequencer and the decode/memory side of the core.
// master = sequencer (drives strobes/requests), slave = datapath/memories/decode.
interface seq_core_ctrl_if #(
   parameter int CNT_W = 32
);
   logic             run_i;
   logic [4:0]       alu_op_i;
   logic             write_reg_i;
   logic             br_taken_i;
   logic             imem_ack_i;
   logic             dmem_ack_i;
   logic             imem_req_o;
   logic             dmem_req_o;
   logic             dmem_we_o;
   logic             ir_we_o;
   logic             rf_we_o;
   logic [1:0]       wb_sel_o;
   logic             pc_we_o;
   logic             pc_sel_o;
   logic             busy_o;
   logic             fault_o;
   logic [1:0]       fault_code_o;
   logic [CNT_W-1:0] instret_o;

   modport master (
      input  run_i, alu_op_i, write_reg_i, br_taken_i, imem_ack_i, dmem_ack_i,
      output imem_req_o, dmem_req_o, dmem_we_o, ir_we_o, rf_we_o, wb_sel_o,
             pc_we_o, pc_sel_o, busy_o, fault_o, fault_code_o, instret_o
   );

   modport slave (
      output run_i, alu_op_i, write_reg_i, br_taken_i, imem_ack_i, dmem_ack_i,
      input  imem_req_o, dmem_req_o, dmem_we_o, ir_we_o, rf_we_o, wb_sel_o,
             pc_we_o, pc_sel_o, busy_o, fault_o, fault_code_o, instret_o
   );
endinterface

// File: rtl/seq_core_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer; 4 cycles per ALU/branch/jal, 5 per lw/sw with zero-wait memory.
// Requests stay high until ack (bounded by MEM_TIMEOUT, then sticky fault); run_i low parks in IDLE at the next boundary.
module seq_core_ctrl #(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 32
) (
   input  logic            clk,
   input  logic            rst,
   seq_core_ctrl_if.master bus
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_FAULT  = 3'd6
   } state_t;

   localparam logic [4:0] OP_ILLEGAL = 5'b00000;
   localparam logic [4:0] OP_JAL     = 5'b10000;
   localparam logic [4:0] OP_BEQ     = 5'b10001;
   localparam logic [4:0] OP_BLT     = 5'b10010;
   localparam logic [4:0] OP_LW      = 5'b10100;
   localparam logic [4:0] OP_SW      = 5'b10101;

   localparam logic [1:0] FC_ILLEGAL = 2'b01;
   localparam logic [1:0] FC_IMEM    = 2'b10;
   localparam logic [1:0] FC_DMEM    = 2'b11;

   localparam int          TW       = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
   localparam logic [TW-1:0] TMO_LAST = TW'(MEM_TIMEOUT - 1);

   state_t           r_state;
   logic [4:0]       r_op;
   logic             r_take;
   logic [TW-1:0]    r_tmo;
   logic [CNT_W-1:0] r_instret;
   logic [1:0]       r_fault_code;

   state_t           w_next;
   logic             w_fault_set;
   logic [1:0]       w_fault_code;
   logic             w_imem_ack;
   logic             w_dmem_ack;
   logic             w_tmo_hit;
   logic             w_op_mem;
   logic             w_enter_wait;
   logic             w_waiting;

   logic             w_imem_req;
   logic             w_dmem_req;
   logic             w_dmem_we;
   logic             w_ir_we;
   logic             w_rf_we;
   logic [1:0]       w_wb_sel;
   logic             w_pc_we;
   logic             w_pc_sel;

   // Acks only count while the matching request is actually up.
   assign w_imem_ack   = (r_state == S_FETCH) && bus.imem_ack_i;
   assign w_dmem_ack   = (r_state == S_MEM) && bus.dmem_ack_i;
   assign w_tmo_hit    = (r_tmo == TMO_LAST);
   assign w_op_mem     = (r_op == OP_LW) || (r_op == OP_SW);
   assign w_enter_wait = (w_next != r_state) && ((w_next == S_FETCH) || (w_next == S_MEM));
   assign w_waiting    = ((r_state == S_FETCH) && !w_imem_ack) ||
                         ((r_state == S_MEM) && !w_dmem_ack);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next       = r_state;
      w_fault_set  = 1'b0;
      w_fault_code = 2'b00;
      case (r_state)
         S_IDLE: begin
            if (bus.run_i) w_next = S_FETCH;
         end
         S_FETCH: begin
            // Ack in the last allowed cycle beats the timeout.
            if (w_imem_ack) begin
               w_next = S_DECODE;
            end else if (w_tmo_hit) begin
               w_next       = S_FAULT;
               w_fault_set  = 1'b1;
               w_fault_code = FC_IMEM;
            end
         end
         S_DECODE: begin
            if (bus.alu_op_i == OP_ILLEGAL) begin
               w_next       = S_FAULT;
               w_fault_set  = 1'b1;
               w_fault_code = FC_ILLEGAL;
            end else begin
               w_next = S_EXEC;
            end
         end
         S_EXEC: begin
            w_next = w_op_mem ? S_MEM : S_WB;
         end
         S_MEM: begin
            if (w_dmem_ack) begin
               w_next = S_WB;
            end else if (w_tmo_hit) begin
               w_next       = S_FAULT;
               w_fault_set  = 1'b1;
               w_fault_code = FC_DMEM;
            end
         end
         S_WB: begin
            w_next = bus.run_i ? S_FETCH : S_IDLE;
         end
         S_FAULT: begin
            w_next = S_FAULT;
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_op         <= 5'b00000;
         r_take       <= 1'b0;
         r_tmo        <= '0;
         r_instret    <= '0;
         r_fault_code <= 2'b00;
      end else begin
         if (r_state == S_DECODE) begin
            r_op <= bus.alu_op_i;
         end
         if (r_state == S_EXEC) begin
            r_take <= (r_op == OP_JAL) ||
                      (((r_op == OP_BEQ) || (r_op == OP_BLT)) && bus.br_taken_i);
         end
         if (w_enter_wait) begin
            r_tmo <= '0;
         end else if (w_waiting) begin
            r_tmo <= r_tmo + 1'b1;
         end
         if (r_state == S_WB) begin
            r_instret <= r_instret + 1'b1;
         end
         if (w_fault_set) begin
            r_fault_code <= w_fault_code;
         end
      end
   end

   always_comb begin
      w_imem_req = 1'b0;
      w_dmem_req = 1'b0;
      w_dmem_we  = 1'b0;
      w_ir_we    = 1'b0;
      w_rf_we    = 1'b0;
      w_wb_sel   = 2'b00;
      w_pc_we    = 1'b0;
      w_pc_sel   = 1'b0;
      case (r_state)
         S_FETCH: begin
            w_imem_req = 1'b1;
            w_ir_we    = bus.imem_ack_i;
         end
         S_MEM: begin
            w_dmem_req = 1'b1;
            w_dmem_we  = (r_op == OP_SW);
         end
         S_WB: begin
            w_pc_we  = 1'b1;
            w_pc_sel = r_take;
            w_rf_we  = bus.write_reg_i;
            if (r_op == OP_LW) begin
               w_wb_sel = 2'b01;
            end else if (r_op == OP_JAL) begin
               w_wb_sel = 2'b10;
            end
         end
         default: begin
            w_imem_req = 1'b0;
         end
      endcase
   end

   assign bus.imem_req_o   = w_imem_req;
   assign bus.dmem_req_o   = w_dmem_req;
   assign bus.dmem_we_o    = w_dmem_we;
   assign bus.ir_we_o      = w_ir_we;
   assign bus.rf_we_o      = w_rf_we;
   assign bus.wb_sel_o     = w_wb_sel;
   assign bus.pc_we_o      = w_pc_we;
   assign bus.pc_sel_o     = w_pc_sel;
   assign bus.busy_o       = (r_state != S_IDLE) && (r_state != S_FAULT);
   assign bus.fault_o      = (r_state == S_FAULT);
   assign bus.fault_code_o = r_fault_code;
   assign bus.instret_o    = r_instret;

   // Architectural strobes must never repeat on back-to-back cycles.
   a_ir_we_single: assert property (@(posedge clk) disable iff (rst) w_ir_we |=> !w_ir_we);
   a_pc_we_single: assert property (@(posedge clk) disable iff (rst) w_pc_we |=> !w_pc_we);
   a_rf_we_single: assert property (@(posedge clk) disable iff (rst) w_rf_we |=> !w_rf_we);

endmodule

// File: tb/tb_seq_core_ctrl.sv
// Bench for seq_core_ctrl: per-instruction cycle timelines built from the instruction rules, replayed against the DUT.
module tb_seq_core_ctrl;
   localparam int TMO = 16;
   localparam logic [4:0] JAL = 5'b10000, BEQ = 5'b10001, BLT = 5'b10010, LW = 5'b10100, SW = 5'b10101;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   seq_core_ctrl_if #(.CNT_W(32)) bus ();
   seq_core_ctrl #(.MEM_TIMEOUT(TMO), .CNT_W(32)) dut (.clk(clk), .rst(rst), .bus(bus));

   typedef struct packed {
      logic        imem_req, dmem_req, dmem_we, ir_we, rf_we;
      logic [1:0]  wb_sel;
      logic        pc_we, pc_sel, busy, fault;
      logic [1:0]  code;
      logic [31:0] instret;
   } out_t;

   typedef struct {
      logic       rst, run, wr, br, iack, dack;
      logic [4:0] op;
      out_t       exp;
   } ent_t;

   ent_t q[$];
   ent_t cur;
   bit   cur_vld = 1'b0;
   int   n_tests = 0, n_fail = 0, n_pcwe = 0, n_cyc = 0;
   int unsigned m_instret = 0;
   logic [1:0]  m_code = 2'b00;
   logic [4:0]  m_op = 5'b00001;

   function automatic ent_t blank();
      ent_t e;
      e.rst = 1'b0;           e.run = 1'($urandom);
      e.wr = 1'($urandom);    e.br = 1'($urandom);
      e.iack = 1'($urandom);  e.dack = 1'($urandom);
      e.op = m_op;
      e.exp = '0;
      e.exp.instret = m_instret;
      e.exp.code = m_code;
      return e;
   endfunction

   // Stopped machine: n cycles with run low, then one with run high to launch the next fetch.
   task automatic gen_idle(input int n);
      ent_t e;
      for (int i = 0; i < n; i++) begin
         e = blank(); e.run = 1'b0; q.push_back(e);
      end
      e = blank(); e.run = 1'b1; q.push_back(e);
   endtask

   task automatic gen_instr(input logic [4:0] op, input logic wr, input logic br, input int iwait,
                            input int dwait, input logic run_wb, input bit abort, output bit faulted);
      ent_t e;
      bit   mem;
      faulted = 1'b0;
      m_op = op;
      mem = (op == LW) || (op == SW);
      for (int i = 0; i < iwait && i < TMO; i++) begin
         e = blank(); e.iack = 1'b0; e.exp.imem_req = 1'b1; e.exp.busy = 1'b1; q.push_back(e);
      end
      if (iwait >= TMO) begin m_code = 2'b10; faulted = 1'b1; return; end
      e = blank(); e.iack = 1'b1; e.exp.imem_req = 1'b1; e.exp.ir_we = 1'b1; e.exp.busy = 1'b1;
      q.push_back(e);
      e = blank(); e.exp.busy = 1'b1; q.push_back(e);
      if (op == 5'b00000) begin m_code = 2'b01; faulted = 1'b1; return; end
      e = blank(); e.br = br; e.exp.busy = 1'b1; q.push_back(e);
      if (mem) begin
         if (abort) begin
            e = blank(); e.rst = 1'b1; e.dack = 1'b0;
            e.exp.dmem_req = 1'b1; e.exp.dmem_we = (op == SW); e.exp.busy = 1'b1;
            q.push_back(e);
            m_instret = 0; m_code = 2'b00;
            return;
         end
         for (int i = 0; i < dwait && i < TMO; i++) begin
            e = blank(); e.dack = 1'b0;
            e.exp.dmem_req = 1'b1; e.exp.dmem_we = (op == SW); e.exp.busy = 1'b1;
            q.push_back(e);
         end
         if (dwait >= TMO) begin m_code = 2'b11; faulted = 1'b1; return; end
         e = blank(); e.dack = 1'b1;
         e.exp.dmem_req = 1'b1; e.exp.dmem_we = (op == SW); e.exp.busy = 1'b1;
         q.push_back(e);
      end
      e = blank(); e.run = run_wb; e.wr = wr;
      e.exp.busy = 1'b1; e.exp.pc_we = 1'b1; e.exp.rf_we = wr;
      e.exp.pc_sel = (op == JAL) || (((op == BEQ) || (op == BLT)) && br);
      e.exp.wb_sel = (op == LW) ? 2'b01 : (op == JAL) ? 2'b10 : 2'b00;
      q.push_back(e);
      m_instret++;
   endtask

   task automatic gen_fault_hold(input int n);
      ent_t e;
      for (int i = 0; i < n; i++) begin
         e = blank(); e.exp.fault = 1'b1; q.push_back(e);
      end
   endtask

   task automatic gen_reset(input bit in_fault);
      ent_t e;
      e = blank(); e.rst = 1'b1; e.exp.fault = in_fault; q.push_back(e);
      m_instret = 0; m_code = 2'b00;
   endtask

   task automatic play();
      while (q.size() > 0) begin
         @(posedge clk); #1;
         cur = q.pop_front();
         rst = cur.rst;
         bus.run_i = cur.run;       bus.alu_op_i = cur.op;
         bus.write_reg_i = cur.wr;  bus.br_taken_i = cur.br;
         bus.imem_ack_i = cur.iack; bus.dmem_ack_i = cur.dack;
         cur_vld = 1'b1;
      end
   endtask

   task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic at_sample();
      @(negedge clk); #1;
   endtask

   always @(negedge clk) begin
      out_t act;
      if (cur_vld) begin
         n_cyc++;
         act = {bus.imem_req_o, bus.dmem_req_o, bus.dmem_we_o, bus.ir_we_o, bus.rf_we_o, bus.wb_sel_o,
                bus.pc_we_o, bus.pc_sel_o, bus.busy_o, bus.fault_o, bus.fault_code_o, bus.instret_o};
         n_tests++;
         if (act !== cur.exp) begin
            n_fail++;
            $display("FAIL cycle%0d outputs: got %h expected %h", n_cyc, act, cur.exp);
         end
         if (bus.pc_we_o === 1'b1) n_pcwe++;
      end
   end

   task automatic run_rand();
      logic [4:0] ops [10];
      logic [4:0] op;
      int   iw, dw, r;
      bit   ab, flt;
      logic rwb;
      ops = '{5'h01, 5'h02, 5'h05, 5'h0a, JAL, BEQ, BLT, LW, SW, LW};
      r = $urandom_range(0, 99);
      op = (r < 3) ? 5'b00000 : ops[$urandom_range(0, 9)];
      iw = ($urandom_range(0, 49) == 0) ? TMO - 1 + $urandom_range(0, 1) : $urandom_range(0, 3);
      dw = ($urandom_range(0, 49) == 0) ? TMO - 1 + $urandom_range(0, 1) : $urandom_range(0, 3);
      ab = ((op == LW) || (op == SW)) && ($urandom_range(0, 29) == 0);
      rwb = ($urandom_range(0, 9) < 7);
      gen_instr(op, 1'($urandom), 1'($urandom), iw, dw, rwb, ab, flt);
      if (flt) begin
         gen_fault_hold($urandom_range(1, 3));
         gen_reset(1'b1);
         gen_idle($urandom_range(0, 2));
      end else if (ab || !rwb) begin
         gen_idle($urandom_range(0, 2));
      end
      play();
   endtask

   initial begin
      bit flt;
      int pcwe_before;
      rst = 1'b1;
      bus.run_i = 1'b0; bus.alu_op_i = 5'b0; bus.write_reg_i = 1'b0; bus.br_taken_i = 1'b0;
      bus.imem_ack_i = 1'b0; bus.dmem_ack_i = 1'b0;
      repeat (2) @(posedge clk);

      // addi with zero-wait fetch, then stop
      gen_idle(1);
      gen_instr(5'h01, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0, flt);
      gen_idle(2);
      play(); at_sample();
      lit("addi_instret", bus.instret_o, 32'd1);
      lit("addi_pcwe_count", n_pcwe, 32'd1);
      lit("addi_busy_idle", {31'd0, bus.busy_o}, 32'd0);

      // lw/sw/branches/jal back to back
      gen_instr(LW,    1'b1, 1'b0, 0, 3, 1'b1, 1'b0, flt);
      gen_instr(SW,    1'b0, 1'b0, 1, 0, 1'b1, 1'b0, flt);
      gen_instr(BEQ,   1'b0, 1'b1, 0, 0, 1'b1, 1'b0, flt);
      gen_instr(BEQ,   1'b0, 1'b0, 0, 0, 1'b1, 1'b0, flt);
      gen_instr(JAL,   1'b1, 1'b0, 2, 0, 1'b1, 1'b0, flt);
      gen_instr(BLT,   1'b0, 1'b1, 0, 0, 1'b1, 1'b0, flt);
      gen_instr(5'h02, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0, flt);
      gen_idle(1);
      play(); at_sample();
      lit("mix_instret", bus.instret_o, 32'd8);
      lit("mix_pcwe_count", n_pcwe, 32'd8);

      // fetch ack on the last allowed cycle, then a fetch timeout
      gen_instr(5'h03, 1'b1, 1'b0, TMO - 1, 0, 1'b1, 1'b0, flt);
      gen_instr(5'h03, 1'b1, 1'b0, TMO, 0, 1'b1, 1'b0, flt);
      gen_fault_hold(3);
      play(); at_sample();
      lit("imem_tmo_fault", {31'd0, bus.fault_o}, 32'd1);
      lit("imem_tmo_code", {30'd0, bus.fault_code_o}, 32'h2);
      lit("imem_tmo_instret", bus.instret_o, 32'd9);
      gen_reset(1'b1);
      gen_idle(1);
      play(); at_sample();
      lit("post_rst_instret", bus.instret_o, 32'd0);
      lit("post_rst_fault", {31'd0, bus.fault_o}, 32'd0);

      // illegal opcode
      pcwe_before = n_pcwe;
      gen_instr(5'b00000, 1'b1, 1'b1, 0, 0, 1'b1, 1'b0, flt);
      gen_fault_hold(4);
      play(); at_sample();
      lit("illegal_code", {30'd0, bus.fault_code_o}, 32'h1);
      lit("illegal_no_pcwe", n_pcwe - pcwe_before, 32'd0);
      gen_reset(1'b1);
      gen_idle(0);

      // reset while waiting on data memory
      gen_instr(5'h04, 1'b1, 1'b0, 0, 0, 1'b1, 1'b0, flt);
      gen_instr(LW, 1'b1, 1'b0, 1, 0, 1'b1, 1'b1, flt);
      gen_idle(1);
      play(); at_sample();
      lit("abort_instret", bus.instret_o, 32'd0);
      lit("abort_dmem_req", {31'd0, bus.dmem_req_o}, 32'd0);

      // data memory timeout on a store
      gen_instr(SW, 1'b0, 1'b0, 0, TMO, 1'b1, 1'b0, flt);
      gen_fault_hold(2);
      play(); at_sample();
      lit("dmem_tmo_code", {30'd0, bus.fault_code_o}, 32'h3);
      gen_reset(1'b1);
      gen_idle(1);
      play();

      for (int i = 0; i < 300; i++) run_rand();

      at_sample();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
